// File: rtl/prng_arbiter.sv
//============================================================================
// Module      : prng_arbiter
// Description : Round-robin arbiter and OBI sequencer sharing one xorshift
//               PRNG among NUM_REQ requesters. Each grant runs a trigger
//               write (BASE_ADDR+0x0) followed by a read (BASE_ADDR+0x4)
//               and returns the fresh value to the winner.
//               Optional feature macro: PRNG_ARB_RETRY_EN (re-issue a
//               failing access up to MAX_RETRY times before reporting error).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module prng_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h2000_1000,
    parameter int          ID_WIDTH  = 3,
    parameter int          MAX_RETRY = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_REQ-1:0]  req_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [NUM_REQ-1:0]  rsp_valid_o,
    output logic [31:0]         rsp_data_o,
    output logic                rsp_err_o,
    output logic                obi_req_o,
    output logic                obi_we_o,
    output logic [3:0]          obi_be_o,
    output logic [31:0]         obi_addr_o,
    output logic [31:0]         obi_wdata_o,
    output logic [ID_WIDTH-1:0] obi_aid_o,
    input  logic                obi_gnt_i,
    input  logic                obi_rvalid_i,
    input  logic [31:0]         obi_rdata_i,
    input  logic                obi_err_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG_REQ  = 3'd1,
        S_TRIG_WAIT = 3'd2,
        S_READ_REQ  = 3'd3,
        S_READ_WAIT = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_win;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W:0]     w_cand;
    logic               w_any;
    logic               w_load;
    logic               w_fail;
    logic               w_can_retry;
    logic [31:0]        r_data;
    logic               r_err;

    // Round-robin search starting one past the last winner, wrapping mod NUM_REQ
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_any && req_i[w_cand[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[IDX_W-1:0];
            end
        end
    end

`ifdef PRNG_ARB_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] r_retry;
    logic               w_trig_ok;
    logic               w_retry;

    assign w_trig_ok = (r_state == S_TRIG_WAIT) && obi_rvalid_i && !obi_err_i;
    assign w_retry   = ((r_state == S_TRIG_WAIT) || (r_state == S_READ_WAIT))
                       && obi_rvalid_i && obi_err_i && w_can_retry;

    // Retry budget: fresh for each access (cleared in IDLE and after a good trigger)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retry <= '0;
        end else if ((r_state == S_IDLE) || w_trig_ok) begin
            r_retry <= '0;
        end else if (w_retry) begin
            r_retry <= r_retry + 1'b1;
        end
    end

    assign w_can_retry = (r_retry < RETRY_W'(MAX_RETRY));
`else
    // Without retry support every error is final; MAX_RETRY has no effect
    assign w_can_retry = 1'b0 & (MAX_RETRY != 0);
`endif

    // Next-state logic and the load/fail strobes for the result registers
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_TRIG_REQ;
            end
            S_TRIG_REQ: begin
                if (obi_gnt_i) w_state_nxt = S_TRIG_WAIT;
            end
            S_TRIG_WAIT: begin
                if (obi_rvalid_i) begin
                    if (!obi_err_i) begin
                        w_state_nxt = S_READ_REQ;
                    end else if (w_can_retry) begin
                        w_state_nxt = S_TRIG_REQ;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_fail      = 1'b1;
                    end
                end
            end
            S_READ_REQ: begin
                if (obi_gnt_i) w_state_nxt = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                if (obi_rvalid_i) begin
                    if (!obi_err_i) begin
                        w_state_nxt = S_RESP;
                        w_load      = 1'b1;
                    end else if (w_can_retry) begin
                        w_state_nxt = S_READ_REQ;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_fail      = 1'b1;
                    end
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus the arbitration pointer and latched winner
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_win   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && w_any) begin
                r_last <= w_win;
                r_win  <= w_win;
            end
        end
    end

    // Result registers hold until the next response overwrites them
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_load) begin
            r_data <= obi_rdata_i;
            r_err  <= 1'b0;
        end else if (w_fail) begin
            r_data <= '0;
            r_err  <= 1'b1;
        end
    end

    // Grant is suppressed during reset since the FSM cannot act on it
    always_comb begin
        gnt_o = '0;
        if (rst_ni && (r_state == S_IDLE) && w_any) gnt_o[w_win] = 1'b1;
    end

    // Result pulse decoded from the RESP state
    always_comb begin
        rsp_valid_o = '0;
        if (r_state == S_RESP) rsp_valid_o[r_win] = 1'b1;
    end

    assign rsp_data_o  = r_data;
    assign rsp_err_o   = r_err;

    // OBI request side decoded from state only
    assign obi_req_o   = (r_state == S_TRIG_REQ) || (r_state == S_READ_REQ);
    assign obi_we_o    = (r_state == S_TRIG_REQ);
    assign obi_addr_o  = (r_state == S_TRIG_REQ) ? BASE_ADDR :
                         (r_state == S_READ_REQ) ? (BASE_ADDR + 32'h4) : 32'h0;
    assign obi_be_o    = 4'hF;
    assign obi_wdata_o = 32'h0;
    assign obi_aid_o   = ID_WIDTH'(r_win);

endmodule

`default_nettype wire

// File: tb/tb_prng_arbiter.sv
//============================================================================
// Module      : tb_prng_arbiter
// Description : Directed bench for prng_arbiter with an OBI xorshift PRNG
//               subordinate model (configurable wait states and errors).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prng_arbiter;

    localparam logic [31:0] BASE = 32'h2000_1000;
    localparam logic [31:0] V1   = 32'h477D_20B7;  // xorshift32 of 0xDEADBEEF

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  req_i = 4'b0000;
    logic [3:0]  gnt_o;
    logic [3:0]  rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        obi_req_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_addr_o;
    logic [31:0] obi_wdata_o;
    logic [2:0]  obi_aid_o;
    logic        obi_gnt_i;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int n_assert = 0;
    int n_fail   = 0;

    prng_arbiter #(
        .NUM_REQ   (4),
        .BASE_ADDR (BASE),
        .ID_WIDTH  (3),
        .MAX_RETRY (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .obi_req_o    (obi_req_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_addr_o   (obi_addr_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_aid_o    (obi_aid_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- OBI PRNG subordinate model ----------------
    int          gnt_delay      = 0;
    int          rv_delay       = 0;
    bit          trig_err_en    = 1'b0;
    int          read_err_limit = 0;
    int          read_mark      = 0;
    int          n_trig;
    int          n_read;
    int          wcnt;
    int          rvcnt;
    bit          pend;
    bit          pend_err;
    logic [31:0] prng;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    assign obi_gnt_i    = obi_req_o && (wcnt >= gnt_delay);
    assign obi_rvalid_i = pend && (rvcnt >= rv_delay);
    assign obi_err_i    = obi_rvalid_i && pend_err;
    assign obi_rdata_i  = pend_err ? 32'hBAD0_BAD0 : prng;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prng     <= 32'hDEAD_BEEF;
            pend     <= 1'b0;
            pend_err <= 1'b0;
            wcnt     <= 0;
            rvcnt    <= 0;
            n_trig   <= 0;
            n_read   <= 0;
        end else begin
            if (obi_req_o && !obi_gnt_i) wcnt <= wcnt + 1;
            else                         wcnt <= 0;
            if (pend) begin
                if (obi_rvalid_i) pend <= 1'b0;
                else              rvcnt <= rvcnt + 1;
            end
            if (obi_req_o && obi_gnt_i) begin
                pend  <= 1'b1;
                rvcnt <= 0;
                if (obi_we_o) begin
                    prng     <= xs32(prng);
                    n_trig   <= n_trig + 1;
                    pend_err <= trig_err_en;
                end else begin
                    n_read   <= n_read + 1;
                    pend_err <= ((n_read - read_mark) < read_err_limit);
                end
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic do_reset();
        req_i  = 4'b0000;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // Counts cycles from the grant cycle to the result pulse; drops req after grant
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) req_i = 4'b0000;
        end while (rsp_valid_o == 4'b0000 && lat < 60);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req_i  = 4'b1111;
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        n_assert++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt_o); end
        n_assert++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid_o); end
        n_assert++; if (rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data_o); end
        n_assert++; if (rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err_o); end
        n_assert++; if (obi_req_o !== 1'b0 || obi_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_obi_req_we: got %b%b expected 00", obi_req_o, obi_we_o); end
        n_assert++; if (obi_addr_o !== 32'h0 || obi_aid_o !== 3'd0) begin n_fail++; $display("FAIL reset_obi_addr_aid: got %h/%0d expected 0/0", obi_addr_o, obi_aid_o); end
        n_assert++; if (obi_be_o !== 4'hF || obi_wdata_o !== 32'h0) begin n_fail++; $display("FAIL const_be_wdata: got %h/%h expected f/0", obi_be_o, obi_wdata_o); end
        req_i  = 4'b0000;
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        n_assert++; if (obi_req_o !== 1'b0 || gnt_o !== 4'b0000) begin n_fail++; $display("FAIL idle_quiet: got req=%b gnt=%b expected 0/0000", obi_req_o, gnt_o); end
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        req_i = 4'b0001;
        #1;
        n_assert++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt_o); end
        wait_rsp(lat);
        n_assert++; if (lat != 5) begin n_fail++; $display("FAIL single_latency: got %0d expected 5", lat); end
        n_assert++; if (rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid_o); end
        n_assert++; if (rsp_data_o !== V1) begin n_fail++; $display("FAIL single_data: got %h expected %h", rsp_data_o, V1); end
        n_assert++; if (rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", rsp_err_o); end
        @(negedge clk_i);
        n_assert++; if (rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0000", rsp_valid_o); end
        n_assert++; if (rsp_data_o !== V1) begin n_fail++; $display("FAIL single_data_hold: got %h expected %h", rsp_data_o, V1); end
    endtask

    task automatic test_contention();
        int ng;
        int prev_c;
        int exp_idx;
        int aid_exp;
        do_reset();
        ng      = 0;
        prev_c  = 0;
        aid_exp = -1;
        req_i   = 4'b1111;
        for (int c = 0; c < 60 && (ng < 5 || aid_exp >= 0); c++) begin
            #1;
            if (aid_exp >= 0) begin
                n_assert++;
                if (obi_req_o !== 1'b1 || obi_aid_o !== 3'(aid_exp)) begin
                    n_fail++; $display("FAIL contention_aid: got req=%b aid=%0d expected 1/%0d", obi_req_o, obi_aid_o, aid_exp);
                end
                aid_exp = -1;
            end
            if (gnt_o !== 4'b0000 && ng < 5) begin
                exp_idx = ng % 4;
                n_assert++;
                if (gnt_o !== 4'(1 << exp_idx)) begin
                    n_fail++; $display("FAIL contention_order: got %b expected index %0d", gnt_o, exp_idx);
                end
                if (ng > 0) begin
                    n_assert++;
                    if (c - prev_c != 6) begin
                        n_fail++; $display("FAIL contention_spacing: got %0d expected 6", c - prev_c);
                    end
                end
                prev_c  = c;
                aid_exp = exp_idx;
                ng++;
            end
            @(negedge clk_i);
        end
        n_assert++; if (ng != 5) begin n_fail++; $display("FAIL contention_count: got %0d expected 5", ng); end
        req_i = 4'b0000;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic test_wait_states();
        int lat;
        int nreq;
        int tmark;
        bit exp_we;
        do_reset();
        gnt_delay = 3;
        rv_delay  = 2;
        tmark     = n_trig;
        nreq      = 0;
        lat       = 0;
        req_i     = 4'b0001;
        #1;
        n_assert++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL wait_gnt: got %b expected 0001", gnt_o); end
        do begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) req_i = 4'b0000;
            if (obi_req_o) begin
                nreq++;
                exp_we = (n_trig == tmark);
                n_assert++;
                if (obi_we_o !== exp_we || obi_addr_o !== (exp_we ? BASE : BASE + 32'h4)) begin
                    n_fail++; $display("FAIL wait_stable: got we=%b addr=%h expected we=%b", obi_we_o, obi_addr_o, exp_we);
                end
            end
        end while (rsp_valid_o == 4'b0000 && lat < 60);
        n_assert++; if (lat != 15) begin n_fail++; $display("FAIL wait_latency: got %0d expected 15", lat); end
        n_assert++; if (nreq != 8) begin n_fail++; $display("FAIL wait_req_cycles: got %0d expected 8", nreq); end
        n_assert++; if (rsp_data_o !== V1 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL wait_data: got %h/%b expected %h/0", rsp_data_o, rsp_err_o, V1); end
        gnt_delay = 0;
        rv_delay  = 0;
        @(negedge clk_i);
    endtask

`ifndef PRNG_ARB_RETRY_EN
    task automatic test_error();
        int lat;
        int rmark;
        do_reset();
        req_i = 4'b0001;
        wait_rsp(lat);
        n_assert++; if (rsp_data_o !== V1) begin n_fail++; $display("FAIL error_pre_data: got %h expected %h", rsp_data_o, V1); end
        @(negedge clk_i);
        rmark       = n_read;
        trig_err_en = 1'b1;
        req_i       = 4'b0100;
        #1;
        n_assert++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL error_gnt: got %b expected 0100", gnt_o); end
        wait_rsp(lat);
        trig_err_en = 1'b0;
        n_assert++; if (lat != 3) begin n_fail++; $display("FAIL error_latency: got %0d expected 3", lat); end
        n_assert++; if (rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL error_rsp_valid: got %b expected 0100", rsp_valid_o); end
        n_assert++; if (rsp_err_o !== 1'b1) begin n_fail++; $display("FAIL error_flag: got %b expected 1", rsp_err_o); end
        n_assert++; if (rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL error_data: got %h expected 0", rsp_data_o); end
        n_assert++; if (n_read - rmark != 0) begin n_fail++; $display("FAIL error_no_read: got %0d reads expected 0", n_read - rmark); end
        @(negedge clk_i);
        n_assert++; if (rsp_err_o !== 1'b1 || rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL error_hold: got err=%b valid=%b expected 1/0000", rsp_err_o, rsp_valid_o); end
        req_i = 4'b0010;
        wait_rsp(lat);
        n_assert++; if (rsp_err_o !== 1'b0 || rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL error_recover: got err=%b valid=%b expected 0/0010", rsp_err_o, rsp_valid_o); end
        @(negedge clk_i);
    endtask
`else
    task automatic test_error();
        int lat;
        int rmark;
        int tmark;
        do_reset();
        rmark          = n_read;
        tmark          = n_trig;
        read_mark      = n_read;
        read_err_limit = 1;
        req_i          = 4'b0001;
        wait_rsp(lat);
        n_assert++; if (lat != 7) begin n_fail++; $display("FAIL retry_latency: got %0d expected 7", lat); end
        n_assert++; if (n_read - rmark != 2) begin n_fail++; $display("FAIL retry_reads: got %0d expected 2", n_read - rmark); end
        n_assert++; if (n_trig - tmark != 1) begin n_fail++; $display("FAIL retry_no_retrigger: got %0d expected 1", n_trig - tmark); end
        n_assert++; if (rsp_data_o !== V1 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL retry_data: got %h/%b expected %h/0", rsp_data_o, rsp_err_o, V1); end
        @(negedge clk_i);
        rmark          = n_read;
        read_mark      = n_read;
        read_err_limit = 3;
        req_i          = 4'b0010;
        wait_rsp(lat);
        read_err_limit = 0;
        n_assert++; if (n_read - rmark != 3) begin n_fail++; $display("FAIL retry_exhaust_reads: got %0d expected 3", n_read - rmark); end
        n_assert++; if (rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL retry_exhaust_valid: got %b expected 0010", rsp_valid_o); end
        n_assert++; if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL retry_exhaust_err: got %b/%h expected 1/0", rsp_err_o, rsp_data_o); end
        @(negedge clk_i);
    endtask
`endif

    task automatic test_reset_mid();
        int lat;
        int c;
        bit seen;
        do_reset();
        req_i = 4'b0001;
        wait_rsp(lat);
        @(negedge clk_i);
        rv_delay = 3;
        req_i    = 4'b0010;
        #1;
        n_assert++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL mid_gnt: got %b expected 0010", gnt_o); end
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 30) begin
            @(negedge clk_i);
            c++;
            if (c == 1) req_i = 4'b0000;
            if (obi_req_o && !obi_we_o) seen = 1'b1;
        end
        @(negedge clk_i);
        n_assert++; if (!seen) begin n_fail++; $display("FAIL mid_read_issued: got %b expected 1", seen); end
        rst_ni = 1'b0;
        #1;
        n_assert++; if (gnt_o !== 4'b0000 || rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_pulses: got %b/%b expected 0000/0000", gnt_o, rsp_valid_o); end
        n_assert++; if (rsp_data_o !== 32'h0 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_result: got %h/%b expected 0/0", rsp_data_o, rsp_err_o); end
        n_assert++; if (obi_req_o !== 1'b0 || obi_we_o !== 1'b0 || obi_addr_o !== 32'h0) begin n_fail++; $display("FAIL mid_reset_obi: got %b/%b/%h expected 0/0/0", obi_req_o, obi_we_o, obi_addr_o); end
        n_assert++; if (obi_aid_o !== 3'd0) begin n_fail++; $display("FAIL mid_reset_aid: got %0d expected 0", obi_aid_o); end
        @(negedge clk_i);
        rst_ni   = 1'b1;
        rv_delay = 0;
        req_i    = 4'b1111;
        #1;
        n_assert++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL mid_first_gnt: got %b expected 0001", gnt_o); end
        wait_rsp(lat);
        n_assert++; if (lat != 5 || rsp_data_o !== V1) begin n_fail++; $display("FAIL mid_after_release: got lat=%0d data=%h expected 5/%h", lat, rsp_data_o, V1); end
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wait_states();
        test_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
